// File: rtl/expr_tx.sv
// Serializes a packed digit/operator expression into ASCII characters, one per
// valid/ready transfer, flagging completion with done and rejected loads with err.
module expr_tx #(
   parameter int unsigned MAX_TERMS = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   start,
   input  logic [4*MAX_TERMS-1:0] digits,
   input  logic [MAX_TERMS-2:0]   ops,
   input  logic [CNT_W-1:0]       nterms,
   output logic [7:0]             out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [2:0] {StIdle, StDigit, StOp, StDone, StErr} state_e;

   state_e                 state;
   logic [CNT_W-1:0]       idx;
   logic [CNT_W-1:0]       idx_nxt;
   logic [CNT_W-1:0]       nt_q;
   logic [4*MAX_TERMS-1:0] dig_q;
   logic [MAX_TERMS-2:0]   ops_q;
   logic                   load_bad;
   logic                   last;
   logic                   cur_op;
   logic [3:0]             nxt_dig;

   // Only digits below nterms are checked; higher slots are don't-care.
   always_comb begin
      load_bad = (nterms == '0) || (nterms > CNT_W'(MAX_TERMS));
      for (int i = 0; i < MAX_TERMS; i++) begin
         if ((CNT_W'(i) < nterms) && (digits[4*i +: 4] > 4'd9)) load_bad = 1'b1;
      end
   end

   assign idx_nxt = idx + 1'b1;
   assign last    = (idx == nt_q - 1'b1);

   always_comb begin
      nxt_dig = '0;
      cur_op  = 1'b0;
      for (int i = 0; i < MAX_TERMS; i++) begin
         if (idx_nxt == CNT_W'(i)) nxt_dig = dig_q[4*i +: 4];
      end
      for (int i = 0; i < MAX_TERMS - 1; i++) begin
         if (idx == CNT_W'(i)) cur_op = ops_q[i];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= StIdle;
         idx       <= '0;
         nt_q      <= '0;
         dig_q     <= '0;
         ops_q     <= '0;
         out       <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  dig_q <= digits;
                  ops_q <= ops;
                  nt_q  <= nterms;
                  idx   <= '0;
                  busy  <= 1'b1;
                  if (load_bad) begin
                     state <= StErr;
                     err   <= 1'b1;
                  end else begin
                     state     <= StDigit;
                     out       <= 8'h30 + {4'h0, digits[3:0]};
                     out_valid <= 1'b1;
                  end
               end
            end
            StDigit: begin
               if (out_ready) begin
                  if (last) begin
                     state     <= StDone;
                     out       <= 8'h00;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= StOp;
                     out   <= cur_op ? 8'h2A : 8'h2B;
                  end
               end
            end
            StOp: begin
               if (out_ready) begin
                  idx   <= idx_nxt;
                  state <= StDigit;
                  out   <= 8'h30 + {4'h0, nxt_dig};
               end
            end
            StDone, StErr: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: streams, backpressure, load rejection, ignored start
// and asynchronous reset mid-stream.
module tb_expr_tx;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [15:0] digits;
   logic [2:0]  ops;
   logic [2:0]  nterms;
   logic [7:0]  out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   expr_tx #(.MAX_TERMS(4), .CNT_W(3)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .digits    (digits),
      .ops       (ops),
      .nterms    (nterms),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Starts one expression and follows it to done; stall selects the 0,0,1 ready
   // pattern, disturb pokes start/digits mid-stream.
   task automatic run_expr(input string tag, input logic [2:0] nt, input logic [15:0] dg,
                           input logic [2:0] op, input bit stall, input bit disturb,
                           input string exp_s);
      int         k;
      int         cyc;
      bit         holding;
      bit         fin;
      logic [7:0] held;
      logic [7:0] e;
      digits    = dg;
      ops       = op;
      nterms    = nt;
      start     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start   = 1'b0;
      k       = 0;
      cyc     = 1;
      holding = 0;
      fin     = 0;
      held    = 8'h00;
      while (!fin && cyc <= 200) begin
         if (holding) begin
            check({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
            check({tag, "_hold_out"}, {24'h0, out}, {24'h0, held});
         end
         holding = 0;
         if (done) begin
            check({tag, "_done_valid"}, {31'h0, out_valid}, 32'h0);
            check({tag, "_done_err"}, {31'h0, err}, 32'h0);
            check({tag, "_count"}, k, exp_s.len());
            if (!stall) check({tag, "_cycles"}, cyc, exp_s.len() + 1);
            fin = 1;
         end else if (out_valid) begin
            out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
            if (out_ready) begin
               e = (k < exp_s.len()) ? exp_s[k] : 8'hFF;
               check({tag, "_char"}, {24'h0, out}, {24'h0, e});
               k++;
            end else begin
               holding = 1;
               held    = out;
            end
         end else begin
            out_ready = 1'b0;
         end
         if (disturb && cyc == 2) begin
            start  = 1'b1;
            digits = 16'h9999;
            nterms = 3'd2;
         end
         if (disturb && cyc == 3) start = 1'b0;
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) check({tag, "_timeout"}, 32'h0, 32'h1);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_idle_done"}, {31'h0, done}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check({tag, "_idle_valid"}, {31'h0, out_valid}, 32'h0);
      end
   endtask

   task automatic run_err(input string tag, input logic [2:0] nt, input logic [15:0] dg);
      digits = dg;
      ops    = 3'b000;
      nterms = nt;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_err"}, {31'h0, err}, 32'h1);
      check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
      @(negedge clk);
      check({tag, "_err_drop"}, {31'h0, err}, 32'h0);
      check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_idle_valid"}, {31'h0, out_valid}, 32'h0);
   endtask

   initial begin
      clr       = 1'b0;
      start     = 1'b0;
      digits    = 16'h0;
      ops       = 3'b000;
      nterms    = 3'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out", {24'h0, out}, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      clr = 1'b1;
      @(negedge clk);
      check("idle_valid", {31'h0, out_valid}, 32'h0);

      run_expr("nine", 3'd2, 16'h0099, 3'b000, 1'b0, 1'b0, "9+9");
      run_expr("long", 3'd4, 16'h7143, 3'b101, 1'b1, 1'b0, "3*4+1*7");
      run_expr("one", 3'd1, 16'h0000, 3'b000, 1'b0, 1'b0, "0");
      run_err("nt0", 3'd0, 16'h0011);
      run_err("nt5", 3'd5, 16'h1111);
      run_err("baddig", 3'd2, 16'h00A0);
      run_expr("unused", 3'd2, 16'h0F25, 3'b000, 1'b0, 1'b0, "5+2");
      run_expr("ignore", 3'd4, 16'h7143, 3'b101, 1'b0, 1'b1, "3*4+1*7");

      // Reset after two transfers; outputs must fall before any clock edge.
      digits    = 16'h0021;
      ops       = 3'b000;
      nterms    = 3'd2;
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_valid_pre", {31'h0, out_valid}, 32'h1);
      #2 clr = 1'b0;
      #1;
      check("mid_valid", {31'h0, out_valid}, 32'h0);
      check("mid_busy", {31'h0, busy}, 32'h0);
      check("mid_done", {31'h0, done}, 32'h0);
      check("mid_out", {24'h0, out}, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("post_rst_done", {31'h0, done}, 32'h0);
      check("post_rst_valid", {31'h0, out_valid}, 32'h0);
      run_expr("restart", 3'd2, 16'h0068, 3'b001, 1'b0, 1'b0, "8*6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/expr_tx.md
Name: expr_tx

Overview:
Serializes a packed arithmetic expression into an ASCII character stream, one character per accepted handshake, in the form digit (op digit)*, for example "9+9" or "3*4+1". It is the transmit-side counterpart of the team's ASCII expression-string checker and drives that checker's 8-bit character input in system benches and in the console path. Inputs are loaded in one cycle on start. Characters are emitted under valid/ready backpressure, and completion is flagged with a done pulse.

Parameters:
MAX_TERMS, 4, maximum number of digit terms per expression (at least 2).
CNT_W, 3, width of nterms and of the internal term index; must hold the value MAX_TERMS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clr  input  1  reset; asynchronous, active-low (0 = reset).
start  input  1  load request; sampled only in IDLE.
digits  input  4*MAX_TERMS  BCD digits; term i is digits[4*i+3:4*i]; term 0 is sent first.
ops  input  MAX_TERMS-1  operator between term i and term i+1: 0 = '+' (8'h2B), 1 = '*' (8'h2A).
nterms  input  CNT_W  number of terms to send, valid range 1..MAX_TERMS.
out  output  8  current ASCII character.
out_valid  output  1  out holds a character to transfer.
out_ready  input  1  sink accepts out this cycle.
busy  output  1  1 in every state except IDLE.
done  output  1  one-cycle pulse after the last character transfers.
err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, index=0, out=8'h00, out_valid=0, busy=0, done=0, err=0. Reset mid-stream abandons the expression; no done pulse follows.
- Transfer: a character is transferred on any rising edge with out_valid=1 and out_ready=1.
- Hold rule: while out_valid=1 and out_ready=0, out must stay stable, and out_valid must stay 1.
- States are IDLE, DIGIT, OP, DONE, ERR.
- IDLE, start=0: remain in IDLE with out_valid=0 and out=8'h00.
- IDLE, start=1: latch digits, ops and nterms into internal registers, and set index=0.
- Load check: the load is rejected if nterms=0, nterms>MAX_TERMS, or any digit at an index below nterms is greater than 9. Digits at indices at or above nterms are don't-care and are never checked.
- Rejected load: go to ERR.
- Accepted load: go to DIGIT. The first out_valid appears in the cycle after start, so latency is 1.
- DIGIT: out = 8'h30 + latched digit[index], out_valid=1.
  - On transfer, if index = nterms-1, go to DONE.
  - On transfer otherwise, go to OP.
- OP: out = '+' or '*' as selected by latched ops[index], out_valid=1.
  - On transfer, index increments and the state goes to DIGIT.
- DONE: one cycle with out_valid=0, out=8'h00, done=1, busy=1; then IDLE.
- ERR: one cycle with err=1, busy=1, out_valid=0; then IDLE.
- start outside IDLE is ignored, and the latched inputs do not change.
- Changes on the digits, ops and nterms inputs after the load have no effect.
- A new start is accepted no earlier than the IDLE cycle that follows DONE or ERR.
- Character count for an expression of n terms is 2n-1.
- With out_ready held at 1, the total cycle count from start to the done pulse is 2n-1+1.
- done and err are never asserted in the same cycle, and never asserted while out_valid=1.
- All outputs are registered; no combinational path from out_ready to out_valid.

Test Plan:
- Single expression: nterms=2, digits term0=9, term1=9, ops[0]=0, out_ready=1, pulse start → out 8'h39, 8'h2B, 8'h39 on three consecutive cycles, then done=1 for one cycle, then busy=0.
- Longest expression and backpressure: nterms=4, digits 3,4,1,7, ops 1,0,1 → stream "3*4+1*7" (8'h33, 2A, 34, 2B, 31, 2A, 37). Drive out_ready as 0,0,1 repeating; out must hold each character stable during the stalls, and exactly 7 transfers must occur before done.
- Boundaries: nterms=1, digit 0 → single 8'h30, then done. Separately, nterms=0 or nterms=5 → err pulse, no out_valid, back to IDLE.
- Digit validity: nterms=2, digit term1=4'hA → err pulse. With nterms=2 and digit term2=4'hF (unused index) → no error; "d+d" is sent normally.
- Ignored start: assert start and change digits while busy → the stream already in progress is unchanged and no second expression follows.
- Reset mid-stream: drive clr=0 after the second character → out_valid, busy and done drop to 0 immediately without waiting for a clock edge. Release reset and restart → the next expression streams correctly from term 0.
